ex_mem_boot_loader: RTL and testbench

- Sequences power-on and reload of the core's instruction and data memories from a 32-bit valid/ready word stream.
- Packs word pairs into the dual-word memory write format (Data1/Data2 per 9-bit address) and drives the external-memory load enable.
- Holds the core in reset while loading, then releases it after a programmable settle delay.
- Sits between the board/host interface and the riscv top-level load ports.

---
 rtl/ex_mem_boot_loader.sv | 216 +++++++++++++++++++++
 tb/tb_ex_mem_boot_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_boot_loader.sv
// Boot loader: packs a 32-bit valid/ready word stream into dual-word instruction/data
// memory writes and holds the core in reset until a settle delay after the last write.
// Optional BOOT_LOADER_CHECKSUM_EN: a trailing XOR checksum word must match before release.
module ex_mem_boot_loader #(
    parameter int ADDR_W         = 9,
    parameter int DATA_W         = 32,
    parameter int RELEASE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   inst_len,
    input  logic [ADDR_W:0]   data_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              inst_we,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_data1,
    output logic [DATA_W-1:0] inst_data2,
    output logic              data_we,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_data1,
    output logic [DATA_W-1:0] data_data2,
    output logic              enable_load_ex_mem,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INST_LO,
        S_INST_HI,
        S_DATA_LO,
        S_DATA_HI,
`ifdef BOOT_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_SETTLE,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [ADDR_W:0] MAX_LEN     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [7:0]      SETTLE_LAST = 8'(RELEASE_CYCLES - 1);
`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam state_t AFTER_LOAD = S_CHK;
`else
    localparam state_t AFTER_LOAD = S_SETTLE;
`endif

    state_t              state_q, state_d;
    logic [ADDR_W:0]     inst_len_q, data_len_q;
    logic [ADDR_W:0]     cnt_q;
    logic [DATA_W-1:0]   lo_q;
    logic [7:0]          settle_q;

    logic accept_start, len_bad, inst_last, data_last;
    logic cap_lo, inst_wr, data_wr, cnt_inc, cnt_clr, release_core, set_err;

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;
`endif

    assign accept_start = start && (state_q == S_IDLE || state_q == S_RUN || state_q == S_ERR);
    assign len_bad      = (inst_len > MAX_LEN) || (data_len > MAX_LEN);
    // The counter is one bit wider than the address, so length 512 ends at 511 without wrapping.
    assign inst_last    = (cnt_q == inst_len_q - 1'b1);
    assign data_last    = (cnt_q == data_len_q - 1'b1);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        state_d      = state_q;
        s_ready      = 1'b0;
        cap_lo       = 1'b0;
        inst_wr      = 1'b0;
        data_wr      = 1'b0;
        cnt_inc      = 1'b0;
        cnt_clr      = 1'b0;
        release_core = 1'b0;
        set_err      = 1'b0;
        case (state_q)
            S_INST_LO, S_DATA_LO: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    cap_lo  = 1'b1;
                    state_d = (state_q == S_INST_LO) ? S_INST_HI : S_DATA_HI;
                end
            end
            S_INST_HI: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    inst_wr = 1'b1;
                    if (inst_last) begin
                        cnt_clr = 1'b1;
                        if (data_len_q != '0) state_d = S_DATA_LO;
                        else                  state_d = AFTER_LOAD;
                    end else begin
                        cnt_inc = 1'b1;
                        state_d = S_INST_LO;
                    end
                end
            end
            S_DATA_HI: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    data_wr = 1'b1;
                    if (data_last) begin
                        cnt_clr = 1'b1;
                        state_d = AFTER_LOAD;
                    end else begin
                        cnt_inc = 1'b1;
                        state_d = S_DATA_LO;
                    end
                end
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            S_CHK: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (s_data == csum_q) begin
                        state_d = S_SETTLE;
                    end else begin
                        set_err = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
`endif
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    release_core = 1'b1;
                    state_d      = S_RUN;
                end
            end
            default: ;
        endcase
        if (accept_start) begin
            if (len_bad)              state_d = S_ERR;
            else if (inst_len != '0)  state_d = S_INST_LO;
            else if (data_len != '0)  state_d = S_DATA_LO;
            else                      state_d = S_SETTLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_len_q <= '0;
            data_len_q <= '0;
            cnt_q      <= '0;
            lo_q       <= '0;
            settle_q   <= '0;
            inst_we    <= 1'b0;
            inst_addr  <= '0;
            inst_data1 <= '0;
            inst_data2 <= '0;
            data_we    <= 1'b0;
            data_addr  <= '0;
            data_data1 <= '0;
            data_data2 <= '0;
            core_reset <= 1'b1;
            error      <= 1'b0;
        end else begin
            inst_we <= inst_wr;
            data_we <= data_wr;
            if (inst_wr) begin
                inst_addr  <= cnt_q[ADDR_W-1:0];
                inst_data1 <= lo_q;
                inst_data2 <= s_data;
            end
            if (data_wr) begin
                data_addr  <= cnt_q[ADDR_W-1:0];
                data_data1 <= lo_q;
                data_data2 <= s_data;
            end
            if (cap_lo) lo_q <= s_data;

            if (accept_start || cnt_clr) cnt_q <= '0;
            else if (cnt_inc)            cnt_q <= cnt_q + 1'b1;

            settle_q <= (state_q == S_SETTLE) ? settle_q + 8'd1 : 8'd0;

            if (accept_start) begin
                inst_len_q <= inst_len;
                data_len_q <= data_len;
                error      <= len_bad;
                core_reset <= 1'b1;
            end else begin
                if (set_err)      error      <= 1'b1;
                if (release_core) core_reset <= 1'b0;
            end
        end
    end

`ifdef BOOT_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || accept_start)
            csum_q <= '0;
        else if (s_valid && s_ready && state_q != S_CHK)
            csum_q <= csum_q ^ s_data;
    end
`endif

    assign busy = !(state_q == S_IDLE || state_q == S_RUN);
    assign done = (state_q == S_RUN);
    assign enable_load_ex_mem = s_ready || inst_we || data_we;

endmodule

// File: tb/tb_ex_mem_boot_loader.sv
// Self-checking bench for ex_mem_boot_loader: random word streams and handshake patterns
// compared cycle by cycle against an index-arithmetic model of the expected writes.
module tb_ex_mem_boot_loader;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int REL    = 4;

    logic              clk = 1'b0;
    logic              reset, start, s_valid;
    logic [ADDR_W:0]   inst_len, data_len;
    logic [DATA_W-1:0] s_data;
    logic              s_ready, inst_we, data_we;
    logic [ADDR_W-1:0] inst_addr, data_addr;
    logic [DATA_W-1:0] inst_data1, inst_data2, data_data1, data_data2;
    logic              enable_load_ex_mem, core_reset, busy, done, error;

    ex_mem_boot_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RELEASE_CYCLES(REL)) dut (
        .clk(clk), .reset(reset), .start(start), .inst_len(inst_len), .data_len(data_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .inst_we(inst_we), .inst_addr(inst_addr), .inst_data1(inst_data1), .inst_data2(inst_data2),
        .data_we(data_we), .data_addr(data_addr), .data_data1(data_data1), .data_data2(data_data2),
        .enable_load_ex_mem(enable_load_ex_mem), .core_reset(core_reset), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model of the held write-port values (they only change on a strobe).
    logic [ADDR_W-1:0] m_ia, m_da;
    logic [DATA_W-1:0] m_id1, m_id2, m_dd1, m_dd2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ports(input string tag);
        check({tag, ".inst_addr"},  64'(inst_addr),  64'(m_ia));
        check({tag, ".inst_data1"}, 64'(inst_data1), 64'(m_id1));
        check({tag, ".inst_data2"}, 64'(inst_data2), 64'(m_id2));
        check({tag, ".data_addr"},  64'(data_addr),  64'(m_da));
        check({tag, ".data_data1"}, 64'(data_data1), 64'(m_dd1));
        check({tag, ".data_data2"}, 64'(data_data2), 64'(m_dd2));
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        tick();
        m_ia = '0; m_da = '0; m_id1 = '0; m_id2 = '0; m_dd1 = '0; m_dd2 = '0;
        check("rst.s_ready", 64'(s_ready), 0);
        check("rst.inst_we", 64'(inst_we), 0);
        check("rst.data_we", 64'(data_we), 0);
        check("rst.enable", 64'(enable_load_ex_mem), 0);
        check("rst.core_reset", 64'(core_reset), 1);
        check("rst.busy", 64'(busy), 0);
        check("rst.done", 64'(done), 0);
        check("rst.error", 64'(error), 0);
        check_ports("rst");
        reset = 1'b0;
        tick();
        check("rst.idle_busy", 64'(busy), 0);
    endtask

    // mode: 0 = valid held high, 1 = valid toggling, 2 = random valid.
    // stop_words != 0 abandons the load once that many words have transferred.
    task automatic run_load(input string tag, input int il, input int dl, input int mode,
                            input int stop_words, input bit bad_sum);
        logic [DATA_W-1:0] words[$];
        logic [DATA_W-1:0] sum;
        int total, w, k, last_edge, pend_kind, pend_idx, budget, e;
        bit xfer, finished;
        bit exp_done, exp_err;
        sum = '0;
        for (int i = 0; i < 2 * (il + dl); i++) begin
            words.push_back($urandom());
            sum ^= words[i];
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        if (il + dl > 0) words.push_back(bad_sum ? (sum ^ 32'h1) : sum);
`endif
        total     = words.size();
        w         = 0;
        k         = 0;
        pend_kind = 0;
        pend_idx  = 0;
        last_edge = (total == 0) ? 0 : -1;
        finished  = 1'b0;
        budget    = 4 * total + REL + 50;

        inst_len = (ADDR_W+1)'(il);
        data_len = (ADDR_W+1)'(dl);
        start    = 1'b1;
        s_valid  = 1'b0;
        s_data   = $urandom();
        tick();
        start = 1'b0;

        for (int cyc = 0; cyc < budget; cyc++) begin
            if (pend_kind == 1) begin
                m_ia  = ADDR_W'(pend_idx / 2);
                m_id1 = words[pend_idx - 1];
                m_id2 = words[pend_idx];
            end else if (pend_kind == 2) begin
                m_da  = ADDR_W'(pend_idx / 2 - il);
                m_dd1 = words[pend_idx - 1];
                m_dd2 = words[pend_idx];
            end
            exp_done = !bad_sum && last_edge >= 0 && (k - last_edge) >= REL;
            exp_err  = bad_sum && last_edge >= 0 && k >= last_edge;
            check({tag, ".inst_we"}, 64'(inst_we), 64'(pend_kind == 1));
            check({tag, ".data_we"}, 64'(data_we), 64'(pend_kind == 2));
            check_ports(tag);
            check({tag, ".s_ready"}, 64'(s_ready), 64'(w < total));
            check({tag, ".enable"}, 64'(enable_load_ex_mem), 64'((w < total) || pend_kind != 0));
            check({tag, ".done"}, 64'(done), 64'(exp_done));
            check({tag, ".core_reset"}, 64'(core_reset), 64'(!exp_done));
            check({tag, ".busy"}, 64'(busy), 64'(!exp_done));
            check({tag, ".error"}, 64'(error), 64'(exp_err));
            if (stop_words != 0 && w == stop_words) begin
                finished = 1'b1;
                break;
            end
            if (last_edge >= 0 && k >= last_edge + REL + 2) begin
                finished = 1'b1;
                break;
            end
            case (mode)
                0:       s_valid = 1'b1;
                1:       s_valid = k[0];
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_data    = (w < total) ? words[w] : $urandom();
            xfer      = s_valid && (w < total);
            pend_kind = 0;
            if (xfer) begin
                e = w / 2;
                if (w % 2 == 1 && e < il)           pend_kind = 1;
                else if (w % 2 == 1 && e < il + dl) pend_kind = 2;
                pend_idx = w;
                w++;
                if (w == total) last_edge = k + 1;
            end
            tick();
            k++;
        end
        s_valid = 1'b0;
        if (!finished) check({tag, ".timeout"}, 1, 0);
    endtask

    task automatic bad_start(input string tag, input int il, input int dl);
        inst_len = (ADDR_W+1)'(il);
        data_len = (ADDR_W+1)'(dl);
        start    = 1'b1;
        s_valid  = 1'b1;
        s_data   = $urandom();
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check({tag, ".error"}, 64'(error), 1);
            check({tag, ".core_reset"}, 64'(core_reset), 1);
            check({tag, ".busy"}, 64'(busy), 1);
            check({tag, ".done"}, 64'(done), 0);
            check({tag, ".s_ready"}, 64'(s_ready), 0);
            check({tag, ".we"}, 64'({inst_we, data_we}), 0);
            check({tag, ".enable"}, 64'(enable_load_ex_mem), 0);
            check_ports(tag);
            s_data = $urandom();
            tick();
        end
        s_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        inst_len = '0;
        data_len = '0;
        do_reset();

        run_load("basic", 2, 1, 0, 0, 1'b0);
        run_load("toggle", 2, 1, 1, 0, 1'b0);
        bad_start("len513", 513, 0);
        run_load("recover", 1, 0, 0, 0, 1'b0);
        bad_start("dlen600", 0, 600);
        run_load("zero", 0, 0, 0, 0, 1'b0);
        run_load("data_only", 0, 3, 2, 0, 1'b0);
        for (int i = 0; i < 6; i++)
            run_load("random", $urandom_range(0, 6), $urandom_range(0, 6), 2, 0, 1'b0);
        run_load("full512", 512, 0, 0, 0, 1'b0);
`ifdef BOOT_LOADER_CHECKSUM_EN
        run_load("csum_ok", 1, 0, 0, 0, 1'b0);
        run_load("csum_bad", 1, 0, 0, 0, 1'b1);
        run_load("csum_recover", 1, 1, 2, 0, 1'b0);
`endif
        run_load("midreset", 512, 0, 0, 200, 1'b0);
        do_reset();
        run_load("after_reset", 1, 1, 2, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
